// File: rtl/layer_xfer_scheduler.sv
// layer_xfer_scheduler
// Sequences a producer conv layer and a consumer pooling layer.
// A run does the following in order:
//   1. Pulse producer compute and wait for producer done.
//   2. Stream every producer output element, in channel/row/col order, into the
//      consumer input memory.
//   3. Pulse consumer compute and wait for consumer done.
//   4. Pulse done.
// Ports:
//   clk, reset (async, active-low)   clock and reset
//   start                            run request, sampled only in idle
//   busy, done                       run status; done is a one-cycle pulse
//   l1_start / l1_done               producer compute handshake
//   rd_ch, rd_row, rd_col            producer output-memory read index
//   wr_en, wr_ch, wr_row, wr_col     consumer input-memory write strobe and index
//   l2_start / l2_done               consumer compute handshake
// All outputs are registered.
module layer_xfer_scheduler #(
  parameter int unsigned NUM_CH   = 16,
  parameter int unsigned DIM      = 26,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned IDX_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             l1_start,
  input  logic             l1_done,
  output logic [IDX_W-1:0] rd_ch,
  output logic [IDX_W-1:0] rd_row,
  output logic [IDX_W-1:0] rd_col,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_ch,
  output logic [IDX_W-1:0] wr_row,
  output logic [IDX_W-1:0] wr_col,
  output logic             l2_start,
  input  logic             l2_done
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StL1Start = 3'd1;
  localparam logic [2:0] StL1Wait  = 3'd2;
  localparam logic [2:0] StXfer    = 3'd3;
  localparam logic [2:0] StDrain   = 3'd4;
  localparam logic [2:0] StL2Start = 3'd5;
  localparam logic [2:0] StL2Wait  = 3'd6;
  localparam logic [2:0] StFinish  = 3'd7;

  localparam logic [IDX_W-1:0] ChLast  = IDX_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0] DimLast = IDX_W'(DIM - 1);

  localparam int unsigned      CntW      = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CntW-1:0]  DrainLast = CntW'(READ_LAT - 1);

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] rd_ch_q, rd_ch_d, rd_row_q, rd_row_d, rd_col_q, rd_col_d;
  logic [CntW-1:0]  drain_cnt_q, drain_cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             l1_start_q, l1_start_d, l2_start_q, l2_start_d;

  // Write pipe: stage 0 captures the read issued this cycle, last stage drives wr_*.
  logic [READ_LAT-1:0]            pv_q, pv_d;
  logic [READ_LAT-1:0][IDX_W-1:0] pch_q, pch_d, prow_q, prow_d, pcol_q, pcol_d;

  always_comb begin
    state_d     = state_q;
    rd_ch_d     = '0;
    rd_row_d    = '0;
    rd_col_d    = '0;
    drain_cnt_d = '0;
    case (state_q)
      StIdle:    if (start) state_d = StL1Start;
      StL1Start: state_d = StL1Wait;
      StL1Wait:  if (l1_done) state_d = StXfer;
      StXfer: begin
        rd_ch_d  = rd_ch_q;
        rd_row_d = rd_row_q;
        if (rd_col_q == DimLast) begin
          rd_col_d = '0;
          if (rd_row_q == DimLast) begin
            rd_row_d = '0;
            if (rd_ch_q == ChLast) begin
              rd_ch_d = '0;
              state_d = StDrain;
            end else begin
              rd_ch_d = rd_ch_q + 1'b1;
            end
          end else begin
            rd_row_d = rd_row_q + 1'b1;
          end
        end else begin
          rd_col_d = rd_col_q + 1'b1;
        end
      end
      // The last read needs READ_LAT cycles to reach the write port.
      StDrain: begin
        if (drain_cnt_q == DrainLast) begin
          state_d = StL2Start;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      StL2Start: state_d = StL2Wait;
      StL2Wait:  if (l2_done) state_d = StFinish;
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with it.
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StFinish);
    l1_start_d = (state_d == StL1Start);
    l2_start_d = (state_d == StL2Start);
  end

  always_comb begin
    pv_d      = pv_q;
    pch_d     = pch_q;
    prow_d    = prow_q;
    pcol_d    = pcol_q;
    pv_d[0]   = (state_q == StXfer);
    pch_d[0]  = (state_q == StXfer) ? rd_ch_q  : '0;
    prow_d[0] = (state_q == StXfer) ? rd_row_q : '0;
    pcol_d[0] = (state_q == StXfer) ? rd_col_q : '0;
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      pv_d[i]   = pv_q[i-1];
      pch_d[i]  = pch_q[i-1];
      prow_d[i] = prow_q[i-1];
      pcol_d[i] = pcol_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rd_ch_q     <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      l1_start_q  <= 1'b0;
      l2_start_q  <= 1'b0;
      pv_q        <= '0;
      pch_q       <= '0;
      prow_q      <= '0;
      pcol_q      <= '0;
    end else begin
      state_q     <= state_d;
      rd_ch_q     <= rd_ch_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      l1_start_q  <= l1_start_d;
      l2_start_q  <= l2_start_d;
      pv_q        <= pv_d;
      pch_q       <= pch_d;
      prow_q      <= prow_d;
      pcol_q      <= pcol_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign l1_start = l1_start_q;
  assign l2_start = l2_start_q;
  assign rd_ch    = rd_ch_q;
  assign rd_row   = rd_row_q;
  assign rd_col   = rd_col_q;
  assign wr_en    = pv_q[READ_LAT-1];
  assign wr_ch    = pch_q[READ_LAT-1];
  assign wr_row   = prow_q[READ_LAT-1];
  assign wr_col   = pcol_q[READ_LAT-1];

endmodule

// File: tb/tb_layer_xfer_scheduler.sv
// Bench for layer_xfer_scheduler: two instances (read latency 1 and 3) share inputs.
// A per-instance timeline model predicts, from the inputs alone, the cycle of each
// pulse and the read/write windows; every output is compared on every falling edge.
module tb_layer_xfer_scheduler;
  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DIM    = 3;
  localparam int unsigned IDX_W  = 16;
  localparam int          NTOT   = NUM_CH * DIM * DIM;
  localparam int          NONE   = -1000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, l1_done = 1'b0, l2_done = 1'b0;

  logic [1:0]       busy_w, done_w, l1s_w, l2s_w, we_w;
  logic [IDX_W-1:0] rc_w [2];
  logic [IDX_W-1:0] rr_w [2];
  logic [IDX_W-1:0] rl_w [2];
  logic [IDX_W-1:0] wc_w [2];
  logic [IDX_W-1:0] wr_w [2];
  logic [IDX_W-1:0] wl_w [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Timeline model state, one entry per instance.
  bit idle_m [2] = '{1'b1, 1'b1};
  bit arm1 [2]   = '{1'b0, 1'b0};
  bit arm2 [2]   = '{1'b0, 1'b0};
  int e_l1s [2]  = '{NONE, NONE};
  int e_fr [2]   = '{NONE, NONE};
  int e_l2s [2]  = '{NONE, NONE};
  int e_done [2] = '{NONE, NONE};

  layer_xfer_scheduler #(.NUM_CH(NUM_CH), .DIM(DIM), .READ_LAT(1), .IDX_W(IDX_W)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_w[0]), .done(done_w[0]),
    .l1_start(l1s_w[0]), .l1_done(l1_done), .rd_ch(rc_w[0]), .rd_row(rr_w[0]),
    .rd_col(rl_w[0]), .wr_en(we_w[0]), .wr_ch(wc_w[0]), .wr_row(wr_w[0]),
    .wr_col(wl_w[0]), .l2_start(l2s_w[0]), .l2_done(l2_done)
  );

  layer_xfer_scheduler #(.NUM_CH(NUM_CH), .DIM(DIM), .READ_LAT(3), .IDX_W(IDX_W)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_w[1]), .done(done_w[1]),
    .l1_start(l1s_w[1]), .l1_done(l1_done), .rd_ch(rc_w[1]), .rd_row(rr_w[1]),
    .rd_col(rl_w[1]), .wr_en(we_w[1]), .wr_ch(wc_w[1]), .wr_row(wr_w[1]),
    .wr_col(wl_w[1]), .l2_start(l2s_w[1]), .l2_done(l2_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rlat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Element n of the transfer in channel/row/col order, packed {ch,row,col}.
  function automatic logic [63:0] idx_of(input int n);
    logic [IDX_W-1:0] ch, row, col;
    ch  = IDX_W'(n / (DIM * DIM));
    row = IDX_W'((n / DIM) % DIM);
    col = IDX_W'(n % DIM);
    return 64'({ch, row, col});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int k);
    int c;
    int rl;
    logic [63:0] rd_e, wr_e;
    bit we_e;
    c  = cyc;
    rl = rlat(k);
    if (!reset) begin
      idle_m[k] = 1'b1; arm1[k] = 1'b0; arm2[k] = 1'b0;
      e_l1s[k] = NONE; e_fr[k] = NONE; e_l2s[k] = NONE; e_done[k] = NONE;
    end
    rd_e = 64'd0;
    wr_e = 64'd0;
    we_e = 1'b0;
    if (e_fr[k] != NONE && c >= e_fr[k] && c < e_fr[k] + NTOT) rd_e = idx_of(c - e_fr[k]);
    if (e_fr[k] != NONE && c >= e_fr[k] + rl && c < e_fr[k] + rl + NTOT) begin
      we_e = 1'b1;
      wr_e = idx_of(c - e_fr[k] - rl);
    end
    chk($sformatf("d%0d_busy@%0d", k, c), 64'(busy_w[k]), 64'(!idle_m[k]));
    chk($sformatf("d%0d_l1_start@%0d", k, c), 64'(l1s_w[k]), 64'(c == e_l1s[k]));
    chk($sformatf("d%0d_l2_start@%0d", k, c), 64'(l2s_w[k]), 64'(c == e_l2s[k]));
    chk($sformatf("d%0d_done@%0d", k, c), 64'(done_w[k]), 64'(c == e_done[k]));
    chk($sformatf("d%0d_rd_idx@%0d", k, c), 64'({rc_w[k], rr_w[k], rl_w[k]}), rd_e);
    chk($sformatf("d%0d_wr_en@%0d", k, c), 64'(we_w[k]), 64'(we_e));
    chk($sformatf("d%0d_wr_idx@%0d", k, c), 64'({wc_w[k], wr_w[k], wl_w[k]}), wr_e);
    if (reset) begin
      if (idle_m[k] && start) begin
        idle_m[k] = 1'b0;
        e_l1s[k]  = c + 1;
        e_fr[k]   = NONE;
      end
      if (arm1[k] && l1_done) begin
        arm1[k]  = 1'b0;
        e_fr[k]  = c + 1;
        e_l2s[k] = c + 1 + NTOT + rl;
      end
      if (c == e_l1s[k]) arm1[k] = 1'b1;
      if (arm2[k] && l2_done) begin
        arm2[k]   = 1'b0;
        e_done[k] = c + 1;
      end
      if (c == e_l2s[k]) arm2[k] = 1'b1;
      if (c == e_done[k]) idle_m[k] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    check_dut(0);
    check_dut(1);
  end

  function automatic bit probe(input int which);
    case (which)
      0:       return l1s_w[0];
      1:       return l2s_w[0];
      2:       return l2s_w[1];
      default: return done_w[1];
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input string tag, input int which, input int bound);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < bound && !seen; n++) begin
      @(negedge clk);
      seen = probe(which);
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    reset = 1'b0;
    step(3);
    reset = 1'b1;
    step(2);

    // Nominal run: l1_done four cycles after l1_start, l2_done three after l2_start.
    start = 1'b1; step(1); start = 1'b0;
    wait_for("nom_l1_start", 0, 10);
    step(4); l1_done = 1'b1; step(1); l1_done = 1'b0;
    wait_for("nom_l2_start", 1, 40);
    step(3); l2_done = 1'b1; step(1); l2_done = 1'b0;
    wait_for("nom_done", 3, 20);
    step(3);

    // Random inputs: start, l1_done and l2_done toggle in every state.
    for (int i = 0; i < 600; i++) begin
      start   = ($urandom_range(0, 99) < 15);
      l1_done = ($urandom_range(0, 99) < 20);
      l2_done = ($urandom_range(0, 99) < 20);
      step(1);
    end
    start = 1'b0; l1_done = 1'b1; l2_done = 1'b1;
    step(40);
    l1_done = 1'b0; l2_done = 1'b0;
    step(2);

    // Reset after five reads, then a full run.
    start = 1'b1; step(1); start = 1'b0;
    wait_for("rst_l1_start", 0, 10);
    step(1); l1_done = 1'b1; step(1); l1_done = 1'b0;
    step(5); reset = 1'b0;
    step(2); reset = 1'b1;
    step(1);
    start = 1'b1; step(1); start = 1'b0;
    wait_for("rerun_l1_start", 0, 10);
    step(2); l1_done = 1'b1; step(1); l1_done = 1'b0;
    wait_for("rerun_l2_start", 2, 40);
    step(1); l2_done = 1'b1; step(1); l2_done = 1'b0;
    wait_for("rerun_done", 3, 20);
    step(2);

    // l1_done and start held high from reset release: back-to-back runs.
    reset = 1'b0; step(2);
    l1_done = 1'b1; l2_done = 1'b1; start = 1'b1;
    reset = 1'b1;
    step(150);
    start = 1'b0;
    step(40);
    l1_done = 1'b0; l2_done = 1'b0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
